// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants, framer states and CRC7 step for the SD SPI command engine
package sd_spi_pkg;
  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD8 = 6'd8;
  localparam logic [5:0] CMD9 = 6'd9;
  localparam logic [5:0] CMD10 = 6'd10;
  localparam logic [5:0] CMD12 = 6'd12;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;
  localparam logic [5:0] CMD59 = 6'd59;
  localparam int R1_IDLE = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC = 3;
  localparam int LEN_R1 = 1;
  localparam int LEN_R3 = 5;
  localparam int LEN_R7 = 5;
  typedef enum logic [2:0] {HUNT, ARG, CRC, EVAL, GAP, RESP} fr_state_t;
  // one byte of CRC7 (x^7 + x^3 + 1), MSB first
  function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r = {r[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return r;
  endfunction
endpackage

// File: rtl/sd_spi_cmd_engine_if.sv
// sd_spi_cmd_engine_if: SPI byte stream and pass-through command bus of the command engine
interface sd_spi_cmd_engine_if;
  logic [7:0] spi_rx_data;
  logic spi_rxdy;
  logic spi_txcomp;
  logic [7:0] spi_tx_data;
  logic cmd_valid;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic card_idle;
  modport master (
    output spi_rx_data, spi_rxdy, spi_txcomp,
    input spi_tx_data, cmd_valid, cmd_index, cmd_arg, card_idle
  );
  modport slave (
    input spi_rx_data, spi_rxdy, spi_txcomp,
    output spi_tx_data, cmd_valid, cmd_index, cmd_arg, card_idle
  );
endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: byte-wide CRC7 accumulator; clear with en restarts the sum on the current byte
module sd_crc7
  import sd_spi_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic clear,
  input logic en,
  input logic [7:0] data,
  output logic [6:0] crc
);
  // accumulate one byte per enabled cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) crc <= '0;
    else if (en) crc <= crc7_byte(clear ? 7'h00 : crc, data);
    else if (clear) crc <= '0;
endmodule

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: frames SD SPI commands, checks CRC7, runs card init and paces responses
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int NCR = 1,
  parameter int ACMD41_BUSY_POLLS = 1,
  parameter logic [31:0] OCR = 32'h40FF8000
) (
  input logic clk,
  input logic rst,
  input logic cs_n,
  sd_spi_cmd_engine_if.slave bus
);
  fr_state_t state, state_nx;
  logic [1:0] cs_sync;
  logic cs_hi, rx_start, crc_feed, eval_fire, pt_fire;
  logic [6:0] crc_calc;
  logic [5:0] idx, cmd_index_q;
  logic [31:0] arg, cmd_arg_q, ext;
  logic [7:0] crc_b, polls, polls_nx, r1;
  logic [1:0] arg_cnt;
  logic [2:0] cnt, len, len_nx;
  logic [39:0] resp_q, resp_nx;
  logic idle, idle_nx, crc_en, crc_en_nx, app, app_nx;
  logic checked, crc_err, illegal, pass;

  assign cs_hi = cs_sync[1];
  assign rx_start = bus.spi_rxdy && !cs_hi && state == HUNT && bus.spi_rx_data[7:6] == 2'b01;
  assign crc_feed = rx_start || (bus.spi_rxdy && state == ARG);
  assign eval_fire = state == EVAL && !cs_hi;
  assign pt_fire = eval_fire && pass;
  assign bus.cmd_valid = pt_fire;
  assign bus.cmd_index = pt_fire ? idx : cmd_index_q;
  assign bus.cmd_arg = pt_fire ? arg : cmd_arg_q;
  assign bus.spi_tx_data = (state == RESP && !cs_hi) ? resp_q[39:32] : 8'hFF;
  assign bus.card_idle = idle;

  sd_crc7 u_crc7 (
    .clk(clk),
    .rst(rst),
    .clear(rx_start),
    .en(crc_feed),
    .data(bus.spi_rx_data),
    .crc(crc_calc)
  );

  // two-flop synchronizer on raw chip select; starts deselected
  always_ff @(posedge clk or negedge rst)
    if (!rst) cs_sync <= 2'b11;
    else cs_sync <= {cs_sync[0], cs_n};

  // framer state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= HUNT;
    else state <= state_nx;

  // framer next state; deselect forces a return to HUNT from anywhere
  always_comb begin
    state_nx = state;
    case (state)
      HUNT: state_nx = rx_start ? ARG : HUNT;
      ARG: state_nx = (bus.spi_rxdy && arg_cnt == 2'd3) ? CRC : ARG;
      CRC: state_nx = bus.spi_rxdy ? EVAL : CRC;
      EVAL: state_nx = GAP;
      GAP: state_nx = (bus.spi_txcomp && cnt == 3'(NCR - 1)) ? RESP : GAP;
      RESP: state_nx = (bus.spi_txcomp && cnt == len - 3'd1) ? HUNT : RESP;
      default: state_nx = HUNT;
    endcase
    if (cs_hi) state_nx = HUNT;
  end

  // capture index, argument (MSB first) and CRC byte of the frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      arg <= '0;
      crc_b <= '0;
      arg_cnt <= '0;
    end else begin
      if (rx_start) begin
        idx <= bus.spi_rx_data[5:0];
        arg_cnt <= '0;
      end
      if (state == ARG && bus.spi_rxdy) begin
        arg <= {arg[23:0], bus.spi_rx_data};
        arg_cnt <= arg_cnt + 2'd1;
      end
      if (state == CRC && bus.spi_rxdy) crc_b <= bus.spi_rx_data;
    end

  // command evaluation: card-state updates and the response image
  always_comb begin
    checked = crc_en || idx == CMD0 || idx == CMD8;
    crc_err = checked && crc_b != {crc_calc, 1'b1};
    idle_nx = idle;
    crc_en_nx = crc_en;
    app_nx = 1'b0;
    polls_nx = polls;
    illegal = 1'b0;
    pass = 1'b0;
    len_nx = 3'(LEN_R1);
    ext = '0;
    if (!crc_err)
      case (idx)
        CMD0: begin
          idle_nx = 1'b1;
          polls_nx = '0;
        end
        CMD8: begin
          len_nx = 3'(LEN_R7);
          ext = {20'h0, arg[11:0]};
        end
        CMD55: app_nx = 1'b1;
        CMD41:
          if (!app) illegal = 1'b1;
          else if (polls < 8'(ACMD41_BUSY_POLLS)) polls_nx = polls + 8'd1;
          else idle_nx = 1'b0;
        CMD58: begin
          len_nx = 3'(LEN_R3);
          ext = {~idle, OCR[30:0]};
        end
        CMD59: crc_en_nx = arg[0];
        CMD9, CMD10, CMD12, CMD16, CMD17, CMD24: begin
          illegal = idle;
          pass = !idle;
        end
        default: illegal = 1'b1;
      endcase
    r1 = '0;
    r1[R1_IDLE] = idle_nx;
    r1[R1_ILLEGAL] = illegal;
    r1[R1_CRC] = crc_err;
    resp_nx = {r1, ext};
  end

  // card init state, committed once per evaluated command
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idle <= 1'b1;
      crc_en <= 1'b0;
      app <= 1'b0;
      polls <= '0;
    end else if (eval_fire) begin
      idle <= idle_nx;
      crc_en <= crc_en_nx;
      app <= app_nx;
      polls <= polls_nx;
    end

  // hold the last accepted pass-through command for the data path
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cmd_index_q <= '0;
      cmd_arg_q <= '0;
    end else if (pt_fire) begin
      cmd_index_q <= idx;
      cmd_arg_q <= arg;
    end

  // response buffer: count NCR filler slots, then shift one byte out per txcomp
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      resp_q <= '0;
      len <= 3'(LEN_R1);
      cnt <= '0;
    end else if (eval_fire) begin
      resp_q <= resp_nx;
      len <= len_nx;
      cnt <= '0;
    end else if (bus.spi_txcomp && state == GAP) cnt <= (cnt == 3'(NCR - 1)) ? '0 : cnt + 3'd1;
    else if (bus.spi_txcomp && state == RESP) begin
      cnt <= cnt + 3'd1;
      resp_q <= resp_q << 8;
    end
endmodule

// File: doc/sd_spi_cmd_engine.md
# sd_spi_cmd_engine

SD-card SPI-mode command engine that sits directly downstream of `SPI_slave` and replaces the byte loopback in `sdio_spi_top`. It consumes received bytes (`spi_data_o`/`spi_rxdy`) and frames them into 6-byte SD commands. It checks CRC7 and runs the card init state (CMD0/8/55/ACMD41/58/59). It returns R1/R3/R7 responses byte by byte on `spi_data_i`, paced by `spi_txcomp`, and passes data-path commands on to a later block.

## Interface
- `NCR`, default 1: 0xFF filler bytes between the CRC byte and the first response byte (1..8).
- `ACMD41_BUSY_POLLS`, default 1: number of ACMD41 commands answered "still idle" before init completes.
- `OCR`, default 32'h40FF8000: OCR returned by CMD58; bit 31 is overridden by `~card_idle`.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-low.
- `cs_n` in 1: raw SSEL, asynchronous, 2-FF synchronized internally.
- `spi_rx_data` in 8: byte received from `SPI_slave`.
- `spi_rxdy` in 1: one-cycle pulse, `spi_rx_data` valid.
- `spi_txcomp` in 1: one-cycle pulse, slave has latched `spi_tx_data` for the next byte.
- `spi_tx_data` out 8: next byte to shift out. Reset value 0xFF.
- `cmd_valid` out 1: one-cycle pulse for an accepted pass-through command. Reset value 0.
- `cmd_index` out 6: index of that command, held until the next pulse. Reset value 0.
- `cmd_arg` out 32: argument of that command, held until the next pulse. Reset value 0.
- `card_idle` out 1: R1 in-idle-state bit. Reset value 1.

## Operation
- Framer states: HUNT, ARG(4 bytes), CRC, EVAL, GAP, RESP.
- HUNT: only a `spi_rxdy` byte with bits[7:6]=2'b01 starts a frame. It captures the index, and CRC7 starts over that byte.
- ARG: captures the argument MSB first.
- CRC: captures the CRC byte.
- EVAL: one cycle, then GAP.
- CRC check: computed CRC7 of bytes 0-4 must equal crc[7:1], and crc[0] must be 1.
- CRC check applies when `crc_en`=1, and always for CMD0 and CMD8. `crc_en` resets to 0.
- On CRC failure: R1 = 0x08|idle, no state change, app flag cleared.
- CMD0: sets idle=1 and clears the app flag and ACMD41 poll count. Response R1.
- CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
- CMD55: sets the app flag. Response R1.
- CMD41 with the app flag set: the first `ACMD41_BUSY_POLLS` return 0x01. After that idle=0 and the response is 0x00.
- CMD58: R3 = R1 followed by the 4 OCR bytes, MSB first.
- CMD59: `crc_en`=arg[0]. Response R1.
- Pass-through commands 9, 10, 12, 16, 17, 24, only when idle=0: response R1=0x00 and `cmd_valid` pulses in EVAL.
- A pass-through command while idle=1, or any other command: R1 = 0x04|idle.
- R1 bit0 is always the current idle value after evaluation.
- The app flag is cleared by every evaluated command except CMD55.
- RX bytes arriving during GAP/RESP are ignored. No new frame is accepted until the engine returns to HUNT.
- Synced `cs_n` high: the framer goes to HUNT immediately, `spi_tx_data`=0xFF, and any pending response is dropped. idle, `crc_en`, the app flag and the poll count are retained.

## Timing
- `spi_rxdy` byte is captured on the same edge; the CRC7 sub-module updates in that cycle.
- EVAL is the cycle after the CRC byte. Response bytes are preloaded into a 5-byte register by the end of EVAL.
- GAP: `spi_tx_data` stays 0xFF. After the NCR-th `spi_txcomp` in GAP, `spi_tx_data` = response byte 0 the next cycle.
- RESP: each `spi_txcomp` advances to the next byte the next cycle. After the last byte's `spi_txcomp`, `spi_tx_data`=0xFF and the state is HUNT.
- `spi_rxdy` and `spi_txcomp` in the same cycle are both processed.
- Environment guarantee: at least 3 clk cycles between a `spi_rxdy` and the following `spi_txcomp`.
- Reset mid-frame: all state returns to its reset values asynchronously.

## Structure
- `sd_spi_pkg`:
  - command index constants (CMD0, 8, 9, 10, 12, 16, 17, 24, 41, 55, 58, 59);
  - R1 bit positions (idle=0, illegal=2, crc=3);
  - framer state enum;
  - response length constants (R1=1, R3/R7=5).
- Sub-module `sd_crc7`: byte-wide CRC7, polynomial x^7+x^3+1, with `clear`, `en` and `data[7:0]` inputs and a `crc[6:0]` output.

## Test plan
- CMD0 `40 00 00 00 00 95`, then clock 0xFF bytes -> 1 byte of 0xFF, then 0x01; `card_idle`=1.
- CMD8 `48 00 00 01 AA 87` -> 0x01 00 00 01 AA.
- CMD55 then ACMD41 `69 40 00 00 00 xx`, sent twice -> first 0x01, second 0x00; `card_idle`=0. CMD58 -> 0x00 C0 FF 80 00.
- CMD0 with CRC byte 0x94 -> R1 0x09; idle unchanged. With `crc_en`=0, CMD17 with a bad CRC is still accepted.
- After init, CMD17 arg 0x00001000 -> R1 0x00 and a `cmd_valid` pulse with index 17, arg 0x1000. CMD17 while idle -> 0x05 and no `cmd_valid`.
- `cs_n` deasserted after 3 bytes of a frame -> `spi_tx_data`=0xFF, the framer is in HUNT, and the next full CMD0 is answered normally.
